// File: rtl/fifo_skew_ctrl_if.sv
// Handshake and FIFO-bank control bundle between the skew controller, its source and the row FIFOs.
interface fifo_skew_ctrl_if #(
  parameter int ROWS = 4
);
  logic            src_valid;
  logic            src_ready;
  logic            stall_in;
  logic            shift_en;
  logic            fifo_stall;
  logic [ROWS-1:0] row_load;
  logic [ROWS-1:0] out_valid;

  modport master (
    input  src_valid, stall_in,
    output src_ready, shift_en, fifo_stall, row_load, out_valid
  );

  modport slave (
    output src_valid, stall_in,
    input  src_ready, shift_en, fifo_stall, row_load, out_valid
  );
endinterface

// File: rtl/fifo_skew_ctrl.sv
// Sequencer for a bank of skewed shift-register FIFOs feeding a systolic array row:
// shared shift enable, per-row load/valid windows delayed by one beat per row, then flush and done.
module fifo_skew_ctrl #(
  parameter int ROWS  = 4,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  fifo_skew_ctrl_if.master bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   beat;
  logic [LEN_W:0]   len_ext;
  logic [LEN_W:0]   feed_last;
  logic [LEN_W:0]   flush_last;
  logic             advance;
  logic             take_start;

  // One extra bit keeps every window bound and beat count free of wrap-around.
  assign len_ext    = {1'b0, len_q};
  assign feed_last  = len_ext - (LEN_W+1)'(1);
  assign flush_last = len_ext + (LEN_W+1)'(ROWS + DEPTH - 2);

  assign advance    = ((state == FEED) && bus.src_valid && !bus.stall_in) ||
                      ((state == FLUSH) && !bus.stall_in);
  assign take_start = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
      beat  <= '0;
    end else begin
      if (take_start && (len != '0)) begin
        len_q <= len;
      end
      if (abort || take_start) begin
        beat <= '0;
      end else if (advance) begin
        beat <= beat + (LEN_W+1)'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (len == '0) ? DONE : FEED;
        FEED:    if (advance && (beat == feed_last)) state_nxt = FLUSH;
        FLUSH:   if (advance && (beat == flush_last)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state != IDLE);
    done           = (state == DONE);
    bus.src_ready  = (state == FEED) && !bus.stall_in;
    bus.shift_en   = advance;
    bus.fifo_stall = busy && !advance;
  end

  // Row r sees the tile r beats late at its input and DEPTH+r beats late at its output.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [LEN_W:0] LOAD_LO  = (LEN_W+1)'(r);
    localparam logic [LEN_W:0] VALID_LO = (LEN_W+1)'(r + DEPTH);

    logic load_ok;
    logic valid_ok;

    if (r == 0) begin : g_load_first
      assign load_ok = (beat < len_ext);
    end else begin : g_load_skew
      assign load_ok = (beat >= LOAD_LO) && (beat < len_ext + LOAD_LO);
    end

    if (r + DEPTH == 0) begin : g_valid_first
      assign valid_ok = (beat < len_ext);
    end else begin : g_valid_skew
      assign valid_ok = (beat >= VALID_LO) && (beat < len_ext + VALID_LO);
    end

    assign bus.row_load[r]  = advance && load_ok;
    assign bus.out_valid[r] = advance && valid_ok;
  end

endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// Directed-vector bench for fifo_skew_ctrl with ROWS=4, DEPTH=4; every expectation is a hand-computed table.
module tb_fifo_skew_ctrl;

  localparam int ROWS  = 4;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  // L=3 tile, indexed by beat number.
  localparam logic [3:0] L3_LOAD  [10] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [3:0] L3_VALID [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
  // L=2 tile with a src_valid gap, indexed by cycle after start.
  localparam logic [3:0] T3_LOAD  [10] = '{4'h1, 4'h0, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [3:0] T3_VALID [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8};
  localparam logic [9:0] T3_SRC   = 10'b00_0000_0101;
  localparam logic [9:0] T3_SHIFT = 10'b11_1111_1101;
  // L=1 tile, indexed by beat number.
  localparam logic [3:0] L1_LOAD  [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [3:0] L1_VALID [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             done;
  int               checks   = 0;
  int               failures = 0;

  fifo_skew_ctrl_if #(.ROWS(ROWS)) bus ();

  fifo_skew_ctrl #(.ROWS(ROWS), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .abort (abort),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] packOut(input logic b, input logic d, input logic r, input logic s,
                                          input logic f, input logic [3:0] rl, input logic [3:0] ov);
    return {19'd0, b, d, r, s, f, rl, ov};
  endfunction

  function automatic logic [31:0] outs();
    return packOut(busy, done, bus.src_ready, bus.shift_en, bus.fifo_stall, bus.row_load, bus.out_valid);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [LEN_W-1:0] ln, input logic ab,
                               input logic sv, input logic si);
    start         = st;
    len           = ln;
    abort         = ab;
    bus.src_valid = sv;
    bus.stall_in  = si;
  endtask

  // Runs an L=3 tile; stallPat bit n stalls the n-th cycle after start. A stray start mid-tile must be ignored.
  task automatic runL3(input logic [31:0] stallPat, input string tag);
    int bi;
    int cyc;
    @(negedge clk);
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    bi  = 0;
    cyc = 0;
    while (bi < 10 && cyc < 40) begin
      @(negedge clk);
      applyStimulus(cyc == 4, 8'd7, 1'b0, 1'b1, stallPat[cyc]);
      #1;
      if (stallPat[cyc]) begin
        checkOutput($sformatf("%s stall c%0d", tag, cyc), outs(),
                    packOut(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0));
      end else begin
        checkOutput($sformatf("%s beat b%0d", tag, bi), outs(),
                    packOut(1'b1, 1'b0, bi < 3, 1'b1, 1'b0, L3_LOAD[bi], L3_VALID[bi]));
        bi++;
      end
      cyc++;
    end
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput({tag, " done"}, outs(), packOut(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0));
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput({tag, " idle after"}, outs(), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset async", outs(), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset held", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    runL3(32'h0, "nostall");
    runL3(32'h106, "stall");

    // L=2 with src_valid 1,0,1,0: the gap freezes the beat, FLUSH follows the second accept.
    @(negedge clk);
    applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'd0, 1'b0, T3_SRC[c], 1'b0);
      #1;
      checkOutput($sformatf("gap c%0d", c),
                  packOut(busy, done, bus.src_valid & bus.src_ready, bus.shift_en, bus.fifo_stall,
                          bus.row_load, bus.out_valid),
                  packOut(1'b1, 1'b0, T3_SRC[c], T3_SHIFT[c], !T3_SHIFT[c], T3_LOAD[c], T3_VALID[c]));
    end
    @(negedge clk);
    #1;
    checkOutput("gap done", outs(), packOut(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0));

    // Zero-length tile goes straight to DONE; a start during DONE is ignored.
    @(negedge clk);
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("len0 done", outs(), packOut(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0));
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("len0 idle", outs(), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("len0 ignored start", outs(), 32'd0);

    // Abort at b=5 of L=3, then an immediate L=1 tile.
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("abort idle", outs(), 32'd0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput($sformatf("l1 beat b%0d", b), outs(),
                  packOut(1'b1, 1'b0, b == 0, 1'b1, 1'b0, L1_LOAD[b], L1_VALID[b]));
    end
    @(negedge clk);
    #1;
    checkOutput("l1 done", outs(), packOut(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0));

    // Asynchronous reset in the middle of FLUSH.
    @(negedge clk);
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    #1;
    checkOutput("flush b4", outs(), packOut(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 4'h1));
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst midflush", outs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("post rst idle c%0d", c), outs(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
